wb_cmd_initiator: RTL and testbench

- Wishbone initiator (master) that converts single-word commands on a valid/ready interface into pipelined Wishbone transactions.
- Drives the slave port of a generated crossbar or register block, e.g. from a host bridge or an I2C-to-WB front end.
- Adds retry on rty, a timeout watchdog, and a registered response channel.
- Only one transaction is outstanding at a time.

---
 rtl/wb_cmd_initiator.sv | 186 ++++++++++++++++++
 tb/tb_wb_cmd_initiator.sv | 238 +++++++++++++++++++++++
 2 files changed

// File: rtl/wb_cmd_initiator.sv
// ---------------------------------------------------------------------------
// wb_cmd_initiator : single-outstanding valid/ready to Wishbone initiator
//                    with rty reissue, timeout watchdog and registered response
// Revision 1.0
// ---------------------------------------------------------------------------
`default_nettype none

module wb_cmd_initiator #(
  parameter int ADDR_WIDTH = 32,
  parameter int TIMEOUT    = 255,
  parameter int MAX_RETRY  = 3
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  cmd_valid_i,
  output logic                  cmd_ready_o,
  input  logic                  cmd_we_i,
  input  logic [ADDR_WIDTH-1:0] cmd_adr_i,
  input  logic [31:0]           cmd_dat_i,
  input  logic [3:0]            cmd_sel_i,
  output logic                  rsp_valid_o,
  input  logic                  rsp_ready_i,
  output logic [31:0]           rsp_dat_o,
  output logic                  rsp_err_o,
  output logic                  rsp_tmo_o,
  output logic                  wb_cyc_o,
  output logic                  wb_stb_o,
  output logic                  wb_we_o,
  output logic [ADDR_WIDTH-1:0] wb_adr_o,
  output logic [3:0]            wb_sel_o,
  output logic [31:0]           wb_dato_o,
  input  logic [31:0]           wb_dati_i,
  input  logic                  wb_ack_i,
  input  logic                  wb_err_i,
  input  logic                  wb_rty_i,
  input  logic                  wb_stall_i
);

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_REQ  = 2'd1;
  localparam logic [1:0] S_WAIT = 2'd2;
  localparam logic [1:0] S_RSP  = 2'd3;

  localparam int TW = (TIMEOUT > 0) ? $clog2(TIMEOUT + 1) : 1;
  localparam int RW = (MAX_RETRY > 0) ? $clog2(MAX_RETRY + 1) : 1;

  logic [1:0]            state_q, state_d;
  logic [TW-1:0]         tmo_q, tmo_d;
  logic [RW-1:0]         retry_q, retry_d;
  logic                  cmd_ready_q, cmd_ready_d;
  logic                  rsp_valid_q, rsp_valid_d;
  logic [31:0]           rsp_dat_q, rsp_dat_d;
  logic                  rsp_err_q, rsp_err_d;
  logic                  rsp_tmo_q, rsp_tmo_d;
  logic                  wb_cyc_q, wb_cyc_d;
  logic                  wb_stb_q, wb_stb_d;
  logic                  wb_we_q, wb_we_d;
  logic [ADDR_WIDTH-1:0] wb_adr_q, wb_adr_d;
  logic [3:0]            wb_sel_q, wb_sel_d;
  logic [31:0]           wb_dato_q, wb_dato_d;

  logic accept, in_bus, rsp_window, any_rsp, tmo_hit, retry_ok;

  // A response only counts once the slave has taken the strobe (not stalled).
  assign accept     = cmd_valid_i & cmd_ready_q;
  assign in_bus     = (state_q == S_REQ) || (state_q == S_WAIT);
  assign rsp_window = (state_q == S_WAIT) || ((state_q == S_REQ) && !wb_stall_i);
  assign any_rsp    = rsp_window && (wb_err_i || wb_rty_i || wb_ack_i);
  assign tmo_hit    = (TIMEOUT != 0) && in_bus && (tmo_q == TW'(TIMEOUT)) && !any_rsp;
  assign retry_ok   = retry_q < RW'(MAX_RETRY);

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= S_IDLE;
      tmo_q       <= '0;
      retry_q     <= '0;
      cmd_ready_q <= 1'b0;
      rsp_valid_q <= 1'b0;
      rsp_dat_q   <= '0;
      rsp_err_q   <= 1'b0;
      rsp_tmo_q   <= 1'b0;
      wb_cyc_q    <= 1'b0;
      wb_stb_q    <= 1'b0;
      wb_we_q     <= 1'b0;
      wb_adr_q    <= '0;
      wb_sel_q    <= '0;
      wb_dato_q   <= '0;
    end else begin
      state_q     <= state_d;
      tmo_q       <= tmo_d;
      retry_q     <= retry_d;
      cmd_ready_q <= cmd_ready_d;
      rsp_valid_q <= rsp_valid_d;
      rsp_dat_q   <= rsp_dat_d;
      rsp_err_q   <= rsp_err_d;
      rsp_tmo_q   <= rsp_tmo_d;
      wb_cyc_q    <= wb_cyc_d;
      wb_stb_q    <= wb_stb_d;
      wb_we_q     <= wb_we_d;
      wb_adr_q    <= wb_adr_d;
      wb_sel_q    <= wb_sel_d;
      wb_dato_q   <= wb_dato_d;
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE: if (accept) state_d = S_REQ;
      S_REQ, S_WAIT: begin
        if (rsp_window && wb_err_i)      state_d = S_RSP;
        else if (rsp_window && wb_rty_i) state_d = retry_ok ? S_REQ : S_RSP;
        else if (rsp_window && wb_ack_i) state_d = S_RSP;
        else if (tmo_hit)                state_d = S_RSP;
        else if (state_q == S_REQ && !wb_stall_i) state_d = S_WAIT;
      end
      S_RSP: if (rsp_valid_q && rsp_ready_i) state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  // Handshake-visible outputs follow the next state so every output is a flop.
  always_comb begin
    cmd_ready_d = (state_d == S_IDLE);
    wb_cyc_d    = (state_d == S_REQ) || (state_d == S_WAIT);
    wb_stb_d    = (state_d == S_REQ);
    rsp_valid_d = (state_d == S_RSP);
    tmo_d       = tmo_q;
    retry_d     = retry_q;
    rsp_dat_d   = rsp_dat_q;
    rsp_err_d   = rsp_err_q;
    rsp_tmo_d   = rsp_tmo_q;
    wb_we_d     = wb_we_q;
    wb_adr_d    = wb_adr_q;
    wb_sel_d    = wb_sel_q;
    wb_dato_d   = wb_dato_q;

    if (accept) begin
      wb_we_d   = cmd_we_i;
      wb_adr_d  = cmd_adr_i & ~ADDR_WIDTH'(3);
      wb_sel_d  = cmd_sel_i;
      wb_dato_d = cmd_dat_i;
      tmo_d     = '0;
      retry_d   = '0;
    end

    if (in_bus && TIMEOUT != 0) tmo_d = tmo_q + TW'(1);

    if (rsp_window && wb_err_i) begin
      rsp_err_d = 1'b1;
      rsp_tmo_d = 1'b0;
      rsp_dat_d = '0;
    end else if (rsp_window && wb_rty_i) begin
      if (retry_ok) begin
        retry_d = retry_q + RW'(1);
      end else begin
        rsp_err_d = 1'b1;
        rsp_tmo_d = 1'b0;
        rsp_dat_d = '0;
      end
    end else if (rsp_window && wb_ack_i) begin
      rsp_err_d = 1'b0;
      rsp_tmo_d = 1'b0;
      rsp_dat_d = wb_we_q ? 32'h0 : wb_dati_i;
    end else if (tmo_hit) begin
      rsp_err_d = 1'b1;
      rsp_tmo_d = 1'b1;
      rsp_dat_d = '0;
    end
  end

  assign cmd_ready_o = cmd_ready_q;
  assign rsp_valid_o = rsp_valid_q;
  assign rsp_dat_o   = rsp_dat_q;
  assign rsp_err_o   = rsp_err_q;
  assign rsp_tmo_o   = rsp_tmo_q;
  assign wb_cyc_o    = wb_cyc_q;
  assign wb_stb_o    = wb_stb_q;
  assign wb_we_o     = wb_we_q;
  assign wb_adr_o    = wb_adr_q;
  assign wb_sel_o    = wb_sel_q;
  assign wb_dato_o   = wb_dato_q;

endmodule

`default_nettype wire

// File: tb/tb_wb_cmd_initiator.sv
// ---------------------------------------------------------------------------
// tb_wb_cmd_initiator : directed bench with response scoreboard
// Revision 1.0
// ---------------------------------------------------------------------------
`default_nettype none

module tb_wb_cmd_initiator;

  logic        clk, rst;
  logic        cmd_valid, cmd_ready, cmd_we;
  logic [31:0] cmd_adr, cmd_dat;
  logic [3:0]  cmd_sel;
  logic        rsp_valid, rsp_ready, rsp_err, rsp_tmo;
  logic [31:0] rsp_dat;
  logic        wb_cyc, wb_stb, wb_we;
  logic [31:0] wb_adr, wb_dato, wb_dati;
  logic [3:0]  wb_sel;
  logic        wb_ack, wb_err, wb_rty, wb_stall;

  typedef struct {
    logic [31:0] dat;
    logic        err;
    logic        tmo;
  } rsp_t;

  rsp_t sb[$];
  int   n_vec = 0;
  int   n_err = 0;

  wb_cmd_initiator #(.ADDR_WIDTH(32), .TIMEOUT(16), .MAX_RETRY(3)) dut (
    .clk(clk), .rst(rst),
    .cmd_valid_i(cmd_valid), .cmd_ready_o(cmd_ready), .cmd_we_i(cmd_we),
    .cmd_adr_i(cmd_adr), .cmd_dat_i(cmd_dat), .cmd_sel_i(cmd_sel),
    .rsp_valid_o(rsp_valid), .rsp_ready_i(rsp_ready), .rsp_dat_o(rsp_dat),
    .rsp_err_o(rsp_err), .rsp_tmo_o(rsp_tmo),
    .wb_cyc_o(wb_cyc), .wb_stb_o(wb_stb), .wb_we_o(wb_we), .wb_adr_o(wb_adr),
    .wb_sel_o(wb_sel), .wb_dato_o(wb_dato), .wb_dati_i(wb_dati),
    .wb_ack_i(wb_ack), .wb_err_i(wb_err), .wb_rty_i(wb_rty), .wb_stall_i(wb_stall)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic clr_slave();
    wb_ack = 1'b0; wb_err = 1'b0; wb_rty = 1'b0;
  endtask

  // Drive one command and return in the first strobe cycle.
  task automatic issue(input logic we, input logic [31:0] adr, input logic [31:0] dat,
                       input logic [3:0] sel);
    int n;
    n = 0;
    cmd_valid = 1'b1; cmd_we = we; cmd_adr = adr; cmd_dat = dat; cmd_sel = sel;
    while (!cmd_ready && n < 20) begin step(); n++; end
    chk("cmd_ready_wait", 64'(n < 20), 64'd1);
    step();
    cmd_valid = 1'b0;
  endtask

  task automatic expect_rsp(input string tag);
    rsp_t e;
    int   n;
    n = 0;
    while (!rsp_valid && n < 40) begin step(); n++; end
    chk({tag, " rsp_valid"}, 64'(rsp_valid), 64'd1);
    if (sb.size() == 0) begin
      n_vec++; n_err++;
      $error("FAIL %s scoreboard: observed empty queue expected an entry", tag);
    end else begin
      e = sb.pop_front();
      chk({tag, " rsp"}, {rsp_err, rsp_tmo, rsp_dat}, {e.err, e.tmo, e.dat});
    end
    rsp_ready = 1'b1;
    step();
    rsp_ready = 1'b0;
    chk({tag, " post_handshake"}, {rsp_valid, cmd_ready}, {1'b0, 1'b1});
  endtask

  initial begin
    int cyc_hi;
    rst = 1'b1; cmd_valid = 1'b0; cmd_we = 1'b0; cmd_adr = '0; cmd_dat = '0; cmd_sel = '0;
    rsp_ready = 1'b0; wb_dati = '0; wb_stall = 1'b0;
    clr_slave();
    step(); step();
    chk("reset_outputs",
        {cmd_ready, rsp_valid, rsp_err, rsp_tmo, wb_cyc, wb_stb, wb_we, wb_sel},
        {1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 4'h0});
    chk("reset_buses", {wb_adr, wb_dato}, 64'h0);
    chk("reset_rsp_dat", rsp_dat, 64'h0);
    rst = 1'b0;
    step();
    chk("ready_after_reset", cmd_ready, 1);

    // Write, ack on the first strobe: minimum turnaround.
    issue(1'b1, 32'h0001_0004, 32'hDEAD_BEEF, 4'hF);
    sb.push_back('{dat: 32'h0, err: 1'b0, tmo: 1'b0});
    chk("wr_bus", {wb_cyc, wb_stb, wb_we, wb_sel, wb_adr},
        {1'b1, 1'b1, 1'b1, 4'hF, 32'h0001_0004});
    chk("wr_dato", wb_dato, 64'hDEAD_BEEF);
    wb_ack = 1'b1;
    step();
    clr_slave();
    chk("wr_stb_one_cycle", {wb_stb, wb_cyc, rsp_valid}, {1'b0, 1'b0, 1'b1});
    expect_rsp("wr");

    // Read with 3 stalled strobe cycles, address low bits must be cleared.
    wb_stall = 1'b1;
    issue(1'b0, 32'h0000_2003, 32'hAAAA_5555, 4'h3);
    sb.push_back('{dat: 32'h1234_5678, err: 1'b0, tmo: 1'b0});
    chk("rd_adr", {wb_we, wb_adr}, {1'b0, 32'h0000_2000});
    cyc_hi = 0;
    for (int i = 0; i < 4; i++) begin
      if (i == 3) wb_stall = 1'b0;
      if (wb_stb && wb_cyc) cyc_hi++;
      step();
    end
    chk("rd_stb_4cyc", 64'(cyc_hi), 64'd4);
    chk("rd_wait", {wb_cyc, wb_stb}, {1'b1, 1'b0});
    step();
    chk("rd_wait2", {wb_cyc, wb_stb}, {1'b1, 1'b0});
    wb_ack = 1'b1; wb_dati = 32'h1234_5678;
    step();
    clr_slave(); wb_dati = 32'hFFFF_FFFF;
    expect_rsp("rd");

    // Two rty then ack: three identical strobes.
    issue(1'b1, 32'h0000_0040, 32'h0BAD_F00D, 4'h5);
    sb.push_back('{dat: 32'h0, err: 1'b0, tmo: 1'b0});
    for (int p = 0; p < 3; p++) begin
      clr_slave();
      chk("rty_pulse", {wb_cyc, wb_stb, wb_we, wb_sel, wb_adr},
          {1'b1, 1'b1, 1'b1, 4'h5, 32'h0000_0040});
      chk("rty_dato", wb_dato, 64'h0BAD_F00D);
      step();
      chk("rty_gap", {wb_cyc, wb_stb}, {1'b1, 1'b0});
      if (p < 2) wb_rty = 1'b1; else wb_ack = 1'b1;
      step();
    end
    clr_slave();
    expect_rsp("rty_ok");

    // Four rty with MAX_RETRY=3: four strobes, then error without timeout flag.
    issue(1'b0, 32'h0000_0080, 32'h0, 4'hF);
    sb.push_back('{dat: 32'h0, err: 1'b1, tmo: 1'b0});
    for (int p = 0; p < 4; p++) begin
      chk("rtyx_pulse", {wb_cyc, wb_stb, wb_adr}, {1'b1, 1'b1, 32'h0000_0080});
      step();
      wb_rty = 1'b1;
      step();
      clr_slave();
    end
    chk("rtyx_end", {wb_stb, wb_cyc, rsp_valid}, {1'b0, 1'b0, 1'b1});
    expect_rsp("rty_exhaust");

    // Silent slave: cyc lasts 17 cycles from the first strobe, then timeout.
    issue(1'b0, 32'h0000_0100, 32'h0, 4'hF);
    sb.push_back('{dat: 32'h0, err: 1'b1, tmo: 1'b1});
    cyc_hi = 0;
    for (int k = 0; k <= 16; k++) begin
      if (wb_cyc) cyc_hi++;
      step();
    end
    chk("tmo_cyc_len", 64'(cyc_hi), 64'd17);
    chk("tmo_drop", {wb_cyc, wb_stb, rsp_valid}, {1'b0, 1'b0, 1'b1});
    step(); step();
    wb_ack = 1'b1; wb_dati = 32'hCAFE_F00D;
    step();
    clr_slave();
    chk("tmo_stray_ack", {rsp_valid, rsp_err, rsp_tmo, rsp_dat, wb_cyc},
        {1'b1, 1'b1, 1'b1, 32'h0, 1'b0});
    expect_rsp("tmo");

    // err+ack together, response backpressure, second command held on valid.
    cmd_valid = 1'b1; cmd_we = 1'b1; cmd_adr = 32'h0000_0200; cmd_dat = 32'h1111_2222;
    cmd_sel = 4'hC;
    sb.push_back('{dat: 32'h0, err: 1'b1, tmo: 1'b0});
    step();
    cmd_we = 1'b0; cmd_adr = 32'h0000_0300; cmd_sel = 4'hF;
    sb.push_back('{dat: 32'h55AA_55AA, err: 1'b0, tmo: 1'b0});
    chk("bp_first_stb", {wb_stb, wb_adr}, {1'b1, 32'h0000_0200});
    wb_err = 1'b1; wb_ack = 1'b1; wb_dati = 32'h9999_9999;
    step();
    clr_slave();
    for (int i = 0; i < 5; i++) begin
      chk("bp_hold", {rsp_valid, rsp_err, rsp_tmo, cmd_ready, wb_cyc, rsp_dat},
          {1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 32'h0});
      step();
    end
    expect_rsp("err_ack");
    chk("no_accept_in_handshake", {wb_cyc, wb_stb}, {1'b0, 1'b0});
    step();
    cmd_valid = 1'b0;
    chk("second_cmd", {wb_stb, wb_we, wb_adr}, {1'b1, 1'b0, 32'h0000_0300});
    wb_ack = 1'b1; wb_dati = 32'h55AA_55AA;
    step();
    clr_slave();
    expect_rsp("second");

    // Reset in WAIT with a coincident ack: everything discarded.
    issue(1'b0, 32'h0000_0400, 32'h0, 4'hF);
    step();
    chk("mid_wait", {wb_cyc, wb_stb}, {1'b1, 1'b0});
    rst = 1'b1; wb_ack = 1'b1; wb_dati = 32'h7777_7777;
    step();
    rst = 1'b0; clr_slave();
    chk("rst_mid", {wb_cyc, wb_stb, rsp_valid, cmd_ready}, {1'b0, 1'b0, 1'b0, 1'b0});
    step();
    chk("rst_recover", {cmd_ready, rsp_valid, wb_cyc}, {1'b1, 1'b0, 1'b0});
    step();
    chk("rsp_stays_idle", {rsp_valid, rsp_err, rsp_dat}, {1'b0, 1'b0, 32'h0});
    chk("sb_drained", 64'(sb.size()), 64'd0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

`default_nettype wire
